// File: rtl/regfile_pkg.sv
// regfile_mp shared constants: init table, register indices, default read-only mask.
package regfile_pkg;

  localparam int REG_X      = 0;
  localparam int REG_Y      = 1;
  localparam int REG_A      = 2;
  localparam int REG_S      = 3;
  localparam int REG_ZERO   = 4;
  localparam int REG_ONE    = 5;
  localparam int REG_MINUS1 = 6;
  localparam int REG_Z      = 7;
  localparam int REG_NMI    = 8;
  localparam int REG_RST    = 9;
  localparam int REG_BRK    = 10;

  localparam logic [31:0] DEF_RO_MASK = 32'h0000_07F0;

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] v;
    v = 8'h00;
    case (i)
      REG_X:      v = 8'h02;
      REG_Y:      v = 8'h03;
      REG_A:      v = 8'h41;
      REG_S:      v = 8'hFF;
      REG_ZERO:   v = 8'h00;
      REG_ONE:    v = 8'h01;
      REG_MINUS1: v = 8'hFF;
      REG_Z:      v = 8'h00;
      REG_NMI:    v = 8'hF9;
      REG_RST:    v = 8'hFB;
      REG_BRK:    v = 8'hFD;
      default:    v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Reset-time init sequencer: writes one table entry per cycle, then parks in RUN.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int NINIT = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          busy,
  output logic          init_we,
  output logic [AW-1:0] init_wa,
  output logic [DW-1:0] init_di
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [AW-1:0] LAST = AW'(NINIT - 1);

  logic [0:0]    state;
  logic [AW-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      idx   <= '0;
    end else if (state == ST_INIT) begin
      if (idx == LAST) begin
        state <= ST_RUN;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign busy    = (state == ST_INIT);
  assign init_we = busy;
  assign init_wa = idx;
  assign init_di = DW'(init_val(int'(idx)));

endmodule

// File: rtl/regfile_mp.sv
// Two-read, one-write register file with per-register write protection.
// Optional write-through forwarding: REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int          DW      = 8,
  parameter int          AW      = 5,
  parameter int          NINIT   = 11,
  parameter logic [31:0] RO_MASK = DEF_RO_MASK
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic          halt,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] di,
  input  logic [AW-1:0] ra_a,
  output logic [DW-1:0] do_a,
  input  logic [AW-1:0] ra_b,
  output logic [DW-1:0] do_b,
  output logic          busy
);

  localparam int NREG = 2 ** AW;
  localparam logic [NREG-1:0] RO = NREG'(RO_MASK);

  if (DW < 8) begin : g_dw_chk
    $error("regfile_mp: DW must be at least 8");
  end
  if (NINIT < 1 || NINIT > NREG) begin : g_ninit_chk
    $error("regfile_mp: NINIT must be in 1..2**AW");
  end

  logic [DW-1:0] regs [NREG];

  logic          init_we;
  logic [AW-1:0] init_wa;
  logic [DW-1:0] init_di;
  logic          we_eff;
  logic          wr_en;
  logic [AW-1:0] wr_a;
  logic [DW-1:0] wr_d;

  regfile_init_seq #(
    .DW    (DW),
    .AW    (AW),
    .NINIT (NINIT)
  ) u_init (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (busy),
    .init_we (init_we),
    .init_wa (init_wa),
    .init_di (init_di)
  );

  assign we_eff = we & rdy & ~halt & ~busy & ~RO[wa];

  // Init path owns the write port while busy, ignoring the read-only mask.
  assign wr_en = init_we | we_eff;
  assign wr_a  = init_we ? init_wa : wa;
  assign wr_d  = init_we ? init_di : di;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs[wr_a] <= wr_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign do_a = (we_eff && wa == ra_a) ? di : regs[ra_a];
  assign do_b = (we_eff && wa == ra_b) ? di : regs[ra_b];
`else
  assign do_a = regs[ra_a];
  assign do_b = regs[ra_b];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: init timing, gated writes, protection,
// same-cycle read/write, mid-init reset, and a DW=16 instance.
module tb_regfile_mp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy;
  logic       halt;
  logic       we;
  logic [4:0] wa;
  logic [7:0] di;
  logic [4:0] ra_a;
  logic [4:0] ra_b;
  logic [7:0] do_a;
  logic [7:0] do_b;
  logic       busy;

  logic [15:0] do_a16;
  logic [15:0] do_b16;
  logic        busy16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .halt  (halt),
    .we    (we),
    .wa    (wa),
    .di    (di),
    .ra_a  (ra_a),
    .do_a  (do_a),
    .ra_b  (ra_b),
    .do_b  (do_b),
    .busy  (busy)
  );

  regfile_mp #(.DW(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .halt  (halt),
    .we    (we),
    .wa    (wa),
    .di    ({8'h00, di}),
    .ra_a  (ra_a),
    .do_a  (do_a16),
    .ra_b  (ra_b),
    .do_b  (do_b16),
    .busy  (busy16)
  );

  typedef struct {
    logic       we;
    logic [4:0] wa;
    logic [7:0] di;
    logic       rdy;
    logic       halt;
    logic [4:0] ra_a;
    logic [4:0] ra_b;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b1;
    halt  = 1'b0;
    we    = 1'b0;
    wa    = '0;
    di    = '0;
    ra_a  = '0;
    ra_b  = '0;

    vt[0] = '{1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd2,  5'd3, 8'h41, 8'hFF};
    vt[1] = '{1'b1, 5'd0,  8'h5A, 1'b1, 1'b1, 5'd0,  5'd1, 8'h02, 8'h03};
    vt[2] = '{1'b1, 5'd0,  8'h5A, 1'b0, 1'b0, 5'd0,  5'd1, 8'h02, 8'h03};
    vt[3] = '{1'b1, 5'd0,  8'h5A, 1'b1, 1'b0, 5'd0,  5'd1, 8'h5A, 8'h03};
    vt[4] = '{1'b1, 5'd4,  8'h77, 1'b1, 1'b0, 5'd4,  5'd5, 8'h00, 8'h01};
    vt[5] = '{1'b1, 5'd12, 8'hC3, 1'b1, 1'b0, 5'd12, 5'd0, 8'hC3, 8'h5A};
    vt[6] = '{1'b1, 5'd10, 8'h00, 1'b1, 1'b0, 5'd10, 5'd8, 8'hFD, 8'hF9};
    vt[7] = '{1'b1, 5'd3,  8'h80, 1'b1, 1'b0, 5'd3,  5'd9, 8'h80, 8'hFB};
    vt[8] = '{1'b1, 5'd31, 8'hE1, 1'b1, 1'b0, 5'd31, 5'd7, 8'hE1, 8'h00};
    vt[9] = '{1'b0, 5'd2,  8'hFF, 1'b1, 1'b0, 5'd2,  5'd6, 8'h41, 8'hFF};

    #2;
    check("reset_busy", 16'(busy), 16'h1);
    tick();
    check("reset_busy_held", 16'(busy), 16'h1);
    rst_n = 1'b1;
    count_busy(n);
    check("init_cycles", 16'(n), 16'd11);
    check("init_busy16", 16'(busy16), 16'h0);

    ra_a = 5'd3;
    ra_b = 5'd2;
    #1;
    check("dw16_s", do_a16, 16'h00FF);
    check("dw16_a", do_b16, 16'h0041);

    for (int i = 0; i < 10; i++) begin
      we   = vt[i].we;
      wa   = vt[i].wa;
      di   = vt[i].di;
      rdy  = vt[i].rdy;
      halt = vt[i].halt;
      ra_a = vt[i].ra_a;
      ra_b = vt[i].ra_b;
      tick();
      we = 1'b0;
      #1;
      check($sformatf("vec%0d_a", i), 16'(do_a), 16'(vt[i].ea));
      check($sformatf("vec%0d_b", i), 16'(do_b), 16'(vt[i].eb));
    end
    rdy  = 1'b1;
    halt = 1'b0;

    // Same-cycle write and read of one register on both ports.
    we   = 1'b1;
    wa   = 5'd1;
    di   = 8'h9C;
    ra_a = 5'd1;
    ra_b = 5'd1;
    #2;
`ifdef REGFILE_BYPASS_EN
    check("byp_pre_a", 16'(do_a), 16'h009C);
    check("byp_pre_b", 16'(do_b), 16'h009C);
`else
    check("byp_pre_a", 16'(do_a), 16'h0003);
    check("byp_pre_b", 16'(do_b), 16'h0003);
`endif
    tick();
    we = 1'b0;
    #1;
    check("byp_post_a", 16'(do_a), 16'h009C);
    check("byp_post_b", 16'(do_b), 16'h009C);

    // Restart init, then reset again at init cycle 5.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("mid_init_busy", 16'(busy), 16'h1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy", 16'(busy), 16'h1);
    tick();
    rst_n = 1'b1;
    rdy   = 1'b0;
    halt  = 1'b1;
    we    = 1'b1;
    wa    = 5'd12;
    di    = 8'h55;
    count_busy(n);
    we   = 1'b0;
    rdy  = 1'b1;
    halt = 1'b0;
    check("restart_cycles", 16'(n), 16'd11);

    ra_a = 5'd0;
    ra_b = 5'd12;
    #1;
    check("reinit_x", 16'(do_a), 16'h0002);
    check("keep_r12", 16'(do_b), 16'h00C3);
    ra_a = 5'd3;
    ra_b = 5'd1;
    #1;
    check("reinit_s", 16'(do_a), 16'h00FF);
    check("reinit_y", 16'(do_b), 16'h0003);
    check("reinit_s16", do_a16, 16'h00FF);

    // First CPU write right after init lands.
    we = 1'b1;
    wa = 5'd2;
    di = 8'h6B;
    ra_a = 5'd2;
    tick();
    we = 1'b0;
    #1;
    check("post_init_wr", 16'(do_a), 16'h006B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised register file for the microcoded 65C02 datapath and its wider variants. It replaces the fixed 8-bit, single-read-port, op-decoded register file. It adds:
- two independent asynchronous read ports;
- an explicit write port with per-register write protection;
- a reset-time init sequencer that loads the architectural and constant registers one entry per cycle.

It sits between the ALU output (write data) and the ALU/address-mux inputs (read data).

## Interface
Parameters:
- DW, 8, data width in bits
- AW, 5, address width; register count NREG = 2**AW
- NINIT, 11, number of registers loaded by the init sequencer (entries 0..NINIT-1); must be ≤ NREG
- RO_MASK, 32'h0000_07F0, bit i set makes register i read-only after init (constants, vector offsets)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  CPU ready; writes gated by it
- halt  in  1  CPU halt; writes gated by its inverse
- we  in  1  write request
- wa  in  AW  write address
- di  in  DW  write data (ALU output)
- ra_a  in  AW  read address, port A
- do_a  out  DW  read data, port A (combinational)
- ra_b  in  AW  read address, port B
- do_b  out  DW  read data, port B (combinational)
- busy  out  1  init sequencer active; CPU must stall while high

## Operation
- Effective write: we_eff = we & rdy & ~halt & ~busy & ~RO_MASK[wa].
- When we_eff is high, regs[wa] <= di at the clock edge. Blocked writes are silently dropped; there is no error flag.
- Reads: do_a = regs[ra_a] and do_b = regs[ra_b], purely combinational. Both ports may address the same register.
- Init FSM states:
  - INIT: counter idx from 0. Each cycle writes INIT_VAL[idx] to regs[idx], ignoring RO_MASK, rdy and halt. idx increments.
  - RUN: entered after writing idx = NINIT-1. Terminal until reset.
- Reset behaviour:
  - rst_n low forces state INIT, idx = 0, busy = 1. Array contents are not reset.
  - Reset asserted mid-INIT or mid-RUN restarts the sequence from idx 0.
  - Registers ≥ NINIT keep their prior contents across reset. They are undefined after power-up.
- Width rule: INIT_VAL entries are DW wide. Package values are 8-bit and zero-extended when DW > 8. DW < 8 is illegal and must be caught by an elaboration-time check.
- Out-of-range addresses cannot occur, since NREG = 2**AW covers the full address space.

## Timing
- Reset values:
  - busy = 1, state = INIT, idx = 0.
  - do_a/do_b follow the array, with no reset value.
- Init takes exactly NINIT cycles after rst_n deasserts. First write happens at the first rising edge with rst_n high.
- busy falls in the same edge that writes entry NINIT-1. The first CPU write can land at edge NINIT+1.
- Write-to-read latency is one edge: data written at edge N appears on do_x after edge N.
- Simultaneous write and read of the same address in one cycle: without bypass, do_x returns the old value until the edge.
- rdy low or halt high during RUN: no writes; reads unaffected.
- rdy and halt have no effect during INIT.

## Configuration
- REGFILE_BYPASS_EN defined: when we_eff is high and wa == ra_x, do_x = di combinationally (write-through forwarding, per port independently).
- REGFILE_BYPASS_EN undefined: reads always return array contents. There is no path from di to do_x.

## Structure
- regfile_pkg holds:
  - INIT_VAL table: 0:X=02, 1:Y=03, 2:A=41, 3:S=FF, 4:00, 5:01, 6:FF, 7:Z=00, 8:F9, 9:FB, 10:FD;
  - register index constants REG_X, REG_Y, REG_A, REG_S, REG_ZERO, REG_ONE, REG_MINUS1, REG_Z, REG_NMI, REG_RST, REG_BRK;
  - the default RO_MASK.
- One sub-module, regfile_init_seq. It holds the FSM and idx counter, and outputs busy, init_we, init_wa, init_di. The top level muxes the init write path over the CPU write path.

## Test plan
- Reset release, then hold rdy = 1 and we = 0 → busy high for exactly 11 cycles. Afterwards do_a at ra_a = 2 reads 41, and do_b at ra_b = 3 reads FF.
- RUN, we = 1, wa = 0, di = 5A, rdy = 1, halt = 0 → after one edge, do_a at ra_a = 0 reads 5A. Repeat with halt = 1 and with rdy = 0 → register still reads 02.
- Write di = 77 to wa = 4 (read-only) → do_a at ra_a = 4 stays 00. A write to wa = 12 (not read-only) succeeds.
- Same-cycle write di = 9C to wa = 1 with ra_a = ra_b = 1 → do_a and do_b read 9C before the edge with REGFILE_BYPASS_EN defined, and 03 before the edge without it. Both read 9C after the edge.
- Assert rst_n low at init cycle 5 for one cycle → sequence restarts at idx 0 and busy stays high 11 more cycles. A CPU write attempted during init is dropped.
- DW = 16 build → after init, ra_a = 3 reads 00FF.
